// File: rtl/fx2_cmd_reader_pkg.sv
// fx2_cmd_reader_pkg: USB constants and FSM encodings shared by the FX2 command reader and stream writer.
package fx2_cmd_reader_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] FREQ_ADDR = 8'h00;

    typedef enum logic [1:0] {BUS_IDLE, BUS_REQ, BUS_OE, BUS_RD} bus_state_t;
    typedef enum logic [1:0] {PRS_HUNT, PRS_BODY, PRS_CHECK} prs_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/fx2_cmd_reader_rd_port.sv
// fx2_rd_port: FX2 slave-FIFO read FSM; requests the bus and strobes one byte per OE/RD pair.
module fx2_rd_port
    import fx2_cmd_reader_pkg::*;
#(
    parameter logic [1:0] EP_ADDR = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_nempty,
    input  logic [7:0] usb_din,
    input  logic       bus_gnt,
    output logic       bus_req,
    output logic [1:0] fifoadr,
    output logic       sloe_n,
    output logic       slrd_n,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);
    bus_state_t state, state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BUS_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BUS_IDLE: state_nx = fifo_nempty ? BUS_REQ : BUS_IDLE;
            BUS_REQ:  state_nx = bus_gnt ? BUS_OE : BUS_REQ;
            BUS_OE:   state_nx = (bus_gnt && fifo_nempty) ? BUS_RD : BUS_IDLE;
            default:  state_nx = BUS_OE;
        endcase
    end

    // The strobe is re-qualified by the live flags so a late grant loss never reads.
    assign rx_valid = (state == BUS_RD) && bus_gnt && fifo_nempty;
    assign rx_byte  = usb_din;
    assign bus_req  = (state != BUS_IDLE);
    assign fifoadr  = bus_req ? EP_ADDR : 2'b00;
    assign sloe_n   = !((state == BUS_OE) || (state == BUS_RD));
    assign slrd_n   = !rx_valid;
endmodule

// File: rtl/fx2_cmd_reader.sv
// fx2_cmd_reader: parses SYNC/ADDR/D3..D0/CHK command frames from the FX2 OUT endpoint into register writes.
module fx2_cmd_reader
    import fx2_cmd_reader_pkg::*;
#(
    parameter logic [7:0] SYNC    = SYNC_BYTE,
    parameter int         TIMEOUT = 48000,
    parameter logic [1:0] EP_ADDR = 2'b00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_nempty,
    input  logic [7:0]  usb_din,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic [1:0]  fifoadr,
    output logic        sloe_n,
    output logic        slrd_n,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic        reg_wr,
    output logic [31:0] freq,
    output logic [7:0]  err_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    prs_state_t    state, state_nx;
    logic [2:0]    idx;
    logic [7:0]    addr, chk;
    logic [31:0]   data;
    logic [TW-1:0] idle_cnt;
    logic          timed_out, chk_ok, frame_err;

    fx2_rd_port #(.EP_ADDR(EP_ADDR)) u_rd_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_nempty (fifo_nempty),
        .usb_din     (usb_din),
        .bus_gnt     (bus_gnt),
        .bus_req     (bus_req),
        .fifoadr     (fifoadr),
        .sloe_n      (sloe_n),
        .slrd_n      (slrd_n),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid)
    );

    // A byte arriving on the expiry cycle wins over the abort.
    assign timed_out = (state != PRS_HUNT) && !rx_valid && (idle_cnt == TW'(TIMEOUT - 1));
    assign chk_ok    = (rx_byte == chk);
    assign frame_err = timed_out || ((state == PRS_CHECK) && rx_valid && !chk_ok);

    always_comb begin
        state_nx = state;
        if (timed_out) state_nx = PRS_HUNT;
        else if (rx_valid)
            case (state)
                PRS_HUNT: state_nx = (rx_byte == SYNC) ? PRS_BODY : PRS_HUNT;
                PRS_BODY: state_nx = (idx == 3'd5) ? PRS_CHECK : PRS_BODY;
                default:  state_nx = PRS_HUNT;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PRS_HUNT;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            addr     <= '0;
            data     <= '0;
            chk      <= '0;
            idle_cnt <= '0;
            reg_addr <= '0;
            reg_data <= '0;
            reg_wr   <= 1'b0;
            freq     <= '0;
            err_cnt  <= '0;
        end else begin
            reg_wr   <= 1'b0;
            idle_cnt <= ((state == PRS_HUNT) || rx_valid) ? '0 : idle_cnt + TW'(1);
            if (rx_valid)
                case (state)
                    PRS_HUNT: begin
                        idx <= 3'd1;
                        chk <= '0;
                    end
                    PRS_BODY: begin
                        idx <= idx + 3'd1;
                        chk <= chk ^ rx_byte;
                        if (idx == 3'd1) addr <= rx_byte;
                        else             data <= {data[23:0], rx_byte};
                    end
                    default: if (chk_ok) begin
                        reg_wr   <= 1'b1;
                        reg_addr <= addr;
                        reg_data <= data;
                        if (addr == FREQ_ADDR) freq <= data;
                    end
                endcase
            if (frame_err) err_cnt <= sat_inc(err_cnt);
        end
    end
endmodule

// File: tb/tb_fx2_cmd_reader.sv
// tb_fx2_cmd_reader: FX2 FIFO model driving table, directed and randomized frame streams into the command reader.
`timescale 1ns/1ps
module tb_fx2_cmd_reader;
    localparam int         TMO = 48000;
    localparam logic [1:0] EP  = 2'b10;

    logic        clk = 1'b0, rst_n = 1'b0, fifo_nempty = 1'b0, bus_gnt = 1'b0;
    logic [7:0]  usb_din = 8'h00;
    logic        bus_req, sloe_n, slrd_n, reg_wr;
    logic [1:0]  fifoadr;
    logic [7:0]  reg_addr, err_cnt;
    logic [31:0] reg_data, freq;

    fx2_cmd_reader #(.SYNC(8'hA5), .TIMEOUT(TMO), .EP_ADDR(EP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_nempty (fifo_nempty),
        .usb_din     (usb_din),
        .bus_gnt     (bus_gnt),
        .bus_req     (bus_req),
        .fifoadr     (fifoadr),
        .sloe_n      (sloe_n),
        .slrd_n      (slrd_n),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .reg_wr      (reg_wr),
        .freq        (freq),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    int          cyc = 0, first_oe = -1, wr_cyc = -1;
    bit          pop_pend = 1'b0;
    logic [7:0]  fifo_q[$];
    logic [39:0] obs_q[$];

    // FX2 side: a strobe seen this cycle pops the head at the next rising edge.
    always @(posedge clk) begin
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        fifo_nempty = (fifo_q.size() != 0);
        usb_din     = fifo_nempty ? fifo_q[0] : 8'h00;
    end

    always @(negedge clk) begin
        cyc++;
        pop_pend = rst_n && !slrd_n;
        if (!slrd_n) begin
            tests++;
            if (sloe_n || !bus_gnt || !fifo_nempty || fifoadr != EP) begin
                fails++;
                $display("FAIL strobe_qual: sloe_n=%b gnt=%b nempty=%b fifoadr=%b, required 0 1 1 %b",
                         sloe_n, bus_gnt, fifo_nempty, fifoadr, EP);
            end
        end
        if (!sloe_n && first_oe < 0) first_oe = cyc;
        if (reg_wr) begin
            obs_q.push_back({reg_addr, reg_data});
            wr_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus_gnt = 1'b0;
        rst_n   = 1'b0;
        fifo_q.delete();
        step(3);
        rst_n = 1'b1;
        obs_q.delete();
        first_oe = -1;
        wr_cyc   = -1;
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("drain_bytes_left", fifo_q.size(), 0);
        step(4);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] a, input logic [31:0] d);
        return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    task automatic push_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] flip);
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(a);
        for (int j = 3; j >= 0; j--) fifo_q.push_back(d[8*j +: 8]);
        fifo_q.push_back(xsum(a, d) ^ flip);
    endtask

    typedef struct {
        logic [71:0] bytes;
        int          n;
        int          exp_wr;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_freq;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_random();
        logic [7:0]  stream[$];
        logic [39:0] exp_q[$];
        logic [7:0]  a, c, b;
        logic [31:0] d;
        logic [31:0] exp_freq = '0;
        int          exp_err = 0, nj, k;
        bit          good;
        do_reset();
        for (int f = 0; f < 60; f++) begin
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom_range(0, 255));
                stream.push_back(b == 8'hA5 ? 8'h3C : b);
            end
            a    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            d    = $urandom();
            good = ($urandom_range(0, 3) != 0);
            c    = xsum(a, d) ^ (good ? 8'h00 : 8'($urandom_range(1, 255)));
            stream.push_back(8'hA5);
            stream.push_back(a);
            for (int j = 3; j >= 0; j--) stream.push_back(d[8*j +: 8]);
            stream.push_back(c);
            if (good) begin
                exp_q.push_back({a, d});
                if (a == 8'h00) exp_freq = d;
            end else exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        while (stream.size() != 0) begin
            step(1);
            bus_gnt = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, 3);
                for (int j = 0; j < k && stream.size() != 0; j++) fifo_q.push_back(stream.pop_front());
            end
        end
        bus_gnt = 1'b1;
        drain();
        check("rand_write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("rand_write", obs_q[i], exp_q[i]);
        check("rand_freq", freq, exp_freq);
        check("rand_err_cnt", err_cnt, exp_err);
        if (exp_q.size() != 0) check("rand_last_reg", {reg_addr, reg_data}, exp_q[exp_q.size()-1]);
    endtask

    initial begin
        vecs[0] = '{72'hA5_00_12_34_56_78_08_00_00, 7, 1, 8'h00, 32'h12345678, 32'h12345678, 8'h00};
        vecs[1] = '{72'hA5_00_12_34_56_78_09_00_00, 7, 0, 8'h00, 32'h00000000, 32'h00000000, 8'h01};
        vecs[2] = '{72'h00_FF_A5_05_00_00_00_01_04, 9, 1, 8'h05, 32'h00000001, 32'h00000000, 8'h00};
        vecs[3] = '{72'hA5_07_A5_A5_00_11_16_00_00, 7, 1, 8'h07, 32'hA5A50011, 32'h00000000, 8'h00};
        vecs[4] = '{72'hA5_00_FF_FF_FF_FF_00_00_00, 7, 1, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00};
        vecs[5] = '{72'hA5_A5_00_00_00_00_A5_00_00, 7, 1, 8'hA5, 32'h00000000, 32'h00000000, 8'h00};

        // Reset holds everything quiet even with data waiting and the bus granted.
        rst_n = 1'b0;
        fifo_q.push_back(8'hA5);
        bus_gnt = 1'b1;
        step(4);
        check("reset_ctrl", {bus_req, sloe_n, slrd_n, fifoadr, reg_wr}, 6'b011000);
        check("reset_regs", {reg_addr, reg_data}, 40'h0);
        check("reset_freq_err", {freq, err_cnt}, 40'h0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < vecs[i].n; j++) fifo_q.push_back(vecs[i].bytes[71-8*j -: 8]);
            bus_gnt = 1'b1;
            drain();
            check($sformatf("vec%0d_wr_count", i), obs_q.size(), vecs[i].exp_wr);
            check($sformatf("vec%0d_reg_addr", i), reg_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_reg_data", i), reg_data, vecs[i].exp_data);
            check($sformatf("vec%0d_freq", i), freq, vecs[i].exp_freq);
            check($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
            if (i == 0) check("latency_oe_to_wr", wr_cyc - first_oe, 14);
        end

        // Mid-frame reset discards the partial frame and clears the held frequency.
        do_reset();
        bus_gnt = 1'b1;
        push_frame(8'h00, 32'h00000055, 8'h00);
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h12);
        drain();
        check("pre_reset_freq", freq, 32'h55);
        rst_n = 1'b0;
        step(2);
        check("midreset_ctrl", {bus_req, sloe_n, slrd_n, fifoadr, reg_wr}, 6'b011000);
        check("midreset_freq_regs", {freq, reg_addr}, 40'h0);
        rst_n = 1'b1;
        obs_q.delete();
        push_frame(8'h03, 32'h0000002A, 8'h00);
        drain();
        check("post_reset_wr_count", obs_q.size(), 1);
        check("post_reset_write", {reg_addr, reg_data}, 40'h03_0000002A);
        check("post_reset_err", err_cnt, 0);

        // Timeout: a stalled frame counts one error only once TIMEOUT idle cycles have elapsed.
        do_reset();
        bus_gnt = 1'b1;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h01);
        drain();
        step(TMO - 20);
        check("timeout_early_err", err_cnt, 0);
        step(40);
        check("timeout_err", err_cnt, 1);
        push_frame(8'h02, 32'h00000007, 8'h00);
        drain();
        check("timeout_next_wr_count", obs_q.size(), 1);
        check("timeout_next_write", {reg_addr, reg_data}, 40'h02_00000007);
        check("timeout_next_err", err_cnt, 1);

        // Grant withdrawn during an OE cycle mid-frame: nothing read, frame still completes.
        begin
            int n = 0;
            do_reset();
            bus_gnt = 1'b1;
            push_frame(8'h00, 32'hCAFEBABE, 8'h00);
            while (!(fifo_q.size() == 4 && !sloe_n && slrd_n) && n < 200) begin
                step(1);
                n++;
            end
            check("gnt_drop_found_oe", (n < 200), 1);
            bus_gnt = 1'b0;
            step(10);
            check("gnt_drop_bytes_kept", fifo_q.size(), 4);
            check("gnt_drop_sloe_n", sloe_n, 1);
            check("gnt_drop_bus_req", bus_req, 1);
            bus_gnt = 1'b1;
            drain();
            check("gnt_drop_wr_count", obs_q.size(), 1);
            check("gnt_drop_data", reg_data, 32'hCAFEBABE);
            check("gnt_drop_freq", freq, 32'hCAFEBABE);
        end

        // Error counter saturates instead of wrapping.
        do_reset();
        bus_gnt = 1'b1;
        for (int i = 0; i < 300; i++) push_frame(8'h00, 32'h0, 8'h01);
        drain();
        check("sat_err_cnt", err_cnt, 8'hFF);
        check("sat_wr_count", obs_q.size(), 0);

        run_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fx2_cmd_reader.md
FX2_CMD_READER -- requirements
Module: fx2_cmd_reader

Interface
REQ-001 Parameter SYNC, default 8'hA5, frame start byte.
REQ-002 Parameter TIMEOUT, default 48000, max idle clk cycles between bytes inside a frame (1 ms at 48 MHz).
REQ-003 Parameter EP_ADDR, default 2'b00, FX2 FIFOADR value for the host-to-FPGA OUT endpoint.
REQ-004 clk  in  1  single clock, the IFCLK domain; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 fifo_nempty  in  1  FX2 OUT-endpoint flag; 1 = at least one byte available.
REQ-007 usb_din  in  8  FX2 data bus, read direction (tristate handled outside).
REQ-008 bus_gnt  in  1  USB bus grant from the stream-writer arbiter.
REQ-009 bus_req  out  1  request for the USB bus.
REQ-010 fifoadr  out  2  endpoint select; EP_ADDR while bus_req=1, else 2'b00.
REQ-011 sloe_n  out  1  FX2 output enable, active-low.
REQ-012 slrd_n  out  1  FX2 read strobe, active-low.
REQ-013 reg_addr  out  8  address of last valid command.
REQ-014 reg_data  out  32  data of last valid command.
REQ-015 reg_wr  out  1  one-cycle pulse per valid command.
REQ-016 freq  out  32  held NCO frequency word, written by address 8'h00.
REQ-017 err_cnt  out  8  saturating count of dropped frames.

Function
REQ-018 Frame: SYNC, ADDR, D3, D2, D1, D0 (MSB first), CHK; CHK = ADDR^D3^D2^D1^D0.
REQ-019 Bus FSM states IDLE, REQ, OE, RD.
- IDLE: bus_req=0; goes to REQ when fifo_nempty=1.
- REQ: bus_req=1; goes to OE when bus_gnt=1.
- OE: sloe_n=0 for one settle cycle; goes to RD when bus_gnt=1 and fifo_nempty=1, else to IDLE.
- RD: sloe_n=0, slrd_n=0 for exactly one cycle; usb_din captured on that edge; then OE.
REQ-020 Sustained throughput: one byte per 2 clk cycles while granted and non-empty.
REQ-021 slrd_n SHALL never be low unless sloe_n is low, bus_gnt=1 and fifo_nempty=1 in the same cycle.
REQ-022 Parser FSM states HUNT, BODY (byte index 1..5), CHECK.
- HUNT: non-SYNC bytes discarded without an error count.
- BODY: bytes are stored into addr/data shift registers.
- CHECK: evaluates the checksum byte.
REQ-023 Good checksum: reg_addr, reg_data and reg_wr=1 all update on the clock after CHK capture (latency 1); freq <= data in the same cycle when addr=8'h00.
REQ-024 Bad checksum: no reg_wr; err_cnt+1; return to HUNT.
REQ-025 Timeout: in BODY/CHECK with no byte captured for TIMEOUT consecutive cycles -> abort to HUNT, err_cnt+1.
REQ-026 err_cnt saturates at 8'hFF, no wrap.
REQ-027 A SYNC byte arriving in BODY is treated as data, no resync.
REQ-028 On bus_gnt loss in REQ/OE: go to IDLE without asserting slrd_n; parser state kept; timeout keeps running.
REQ-029 Timeout abort and a byte capture in the same cycle: the capture wins, timer reloads.

Reset
REQ-030 While rst_n=0, outputs hold: bus_req=0, sloe_n=1, slrd_n=1, fifoadr=2'b00, reg_wr=0, reg_addr=0, reg_data=0, freq=0, err_cnt=0; FSMs are in IDLE/HUNT; timer is cleared.
REQ-031 Reset asserted mid-frame discards the partial frame; after release the block restarts in HUNT.

Structure
REQ-032 SYNC default, state encodings and the FREQ address constant (8'h00) SHALL live in the shared USB package with the stream writer.
REQ-033 One sub-module, fx2_rd_port, SHALL contain the bus FSM and present byte/valid to the parser.

Verification
REQ-034 Frame A5 00 12 34 56 78 CHK=08 with gnt held -> reg_wr pulse, reg_addr=00, reg_data=12345678, freq=12345678, 14 cycles from first OE.
REQ-035 Same frame with CHK=09 -> no reg_wr, freq unchanged, err_cnt=1.
REQ-036 Bytes 00 FF A5 05 00 00 00 01 CHK=04 -> leading 00/FF skipped, reg_addr=05, reg_data=00000001, freq unchanged, err_cnt=0.
REQ-037 A5 01 then 48000 idle cycles -> err_cnt=1, HUNT; next valid frame accepted.
REQ-038 bus_gnt dropped during OE -> slrd_n stays 1, no byte lost; frame completes correctly after re-grant.
REQ-039 300 bad frames -> err_cnt=FF.
